relu_requant: RTL
=================

// Module: relu_requant
// PURPOSE
//  Streaming activation stage directly upstream of the 2x2 max-pool. Takes signed
//  conv accumulator samples in raster order, one per handshake, and applies ReLU,
//  arithmetic right-shift requantization and unsigned saturation to DATA_WIDTH.
//  Tags each output with its (row,col) so the pool frame buffer can write it in
//  place. Signals frame completion.
// PARAMETERS
//  IFMAP_HEIGHT  128  rows per frame (even, >=2)
//  IFMAP_WIDTH   128  columns per frame (even, >=2)
//  ACC_WIDTH     20   signed accumulator input width
//  DATA_WIDTH    8    unsigned output width (matches max-pool DATA_WIDTH)
//  SHIFT         6    requant right-shift amount, 0..ACC_WIDTH-1
// PORTS
//  clk        in   1                         clock, rising edge
//  reset      in   1                         synchronous, active-high
//  en         in   1                         frame start request, sampled in IDLE only
//  in_valid   in   1                         in_data valid
//  in_ready   out  1                         stage accepts in_data this cycle
//  in_data    in   ACC_WIDTH                 signed accumulator sample
//  out_valid  out  1                         out_data/out_row/out_col valid
//  out_ready  in   1                         consumer accepts output
//  out_data   out  DATA_WIDTH                activated, requantized pixel
//  out_row    out  $clog2(IFMAP_HEIGHT)      row of out_data
//  out_col    out  $clog2(IFMAP_WIDTH)       column of out_data
//  sat_flag   out  1                         sticky: a positive value clipped this frame
//  done_relu  out  1                         level: frame fully emitted
// BEHAVIOUR
//  - Reset (synchronous, active-high, any state incl. mid-frame): state=IDLE, pipe
//    emptied, all outputs 0 next edge, in-flight data dropped.
//  - FSM: IDLE -(en)-> RUN; RUN -(last pixel accepted)-> FLUSH;
//    FLUSH -(pipe empty)-> DONE; DONE -(!en)-> IDLE.
//    en held high in DONE keeps done_relu=1, no restart.
//  - 2-stage pipe, one global advance = !s2_valid | out_ready.
//    in_ready = (state==RUN) & advance. Transfer on valid&ready on each side.
//  - Latency: accepted sample appears on out_* 2 cycles later when out_ready=1.
//    Throughput 1/cycle. out_* held stable while out_valid & !out_ready.
//  - S1: ReLU. in_data<=0 -> 0; else v = in_data >> SHIFT (truncate).
//  - S2: v > 2^DATA_WIDTH-1 -> out_data = all-ones and sat_flag<=1; else v[DATA_WIDTH-1:0].
//  - Input counter counts accepted samples 0..H*W-1. Output col wraps at
//    IFMAP_WIDTH-1 to 0 and increments row. Both clear on IDLE->RUN.
//    sat_flag clears on IDLE->RUN.
//  - in_valid in IDLE/FLUSH/DONE: ignored, in_ready=0.
//    en toggles during RUN/FLUSH: ignored.
//  - done_relu=1 only in DONE, asserted the cycle after final out transfer.
//  - Simultaneous last-input accept and output stall: pipe holds, FLUSH waits.
// CONFIGURATION
//  RELU_ROUND_EN defined: S1 uses round-half-up,
//    v = (in_data + (1<<(SHIFT-1))) >> SHIFT, computed at ACC_WIDTH+1 bits.
//    No effect when SHIFT=0.
//  RELU_ROUND_EN undefined: truncation as above. Ports, latency and FSM identical.
// TESTING
//  1. 4x4 frame, SHIFT=2, inputs 0..15, out_ready=1
//     -> outputs 0,0,0,0,1,1,1,1,2..3, row/col raster, done_relu after 18 cycles.
//  2. in_data=-5, 0, 1000 (SHIFT=2)
//     -> 0, 0, 250 (sat_flag=0); in_data=2000 -> 255, sat_flag=1.
//  3. out_ready low 5 cycles mid-frame
//     -> out_* stable, in_ready=0 after pipe fills, no loss/duplicate, order kept.
//  4. reset pulse mid-frame (pixel 7 of 16)
//     -> next cycle out_valid=0, in_ready=0, done_relu=0.
//     en then restarts at row0/col0.
//  5. RELU_ROUND_EN, SHIFT=2: in 6 -> 2, 5 -> 1; without macro: 6 -> 1, 5 -> 1.
//  6. en held high through DONE -> done_relu stays 1, in_ready 0.
//     en low -> IDLE, done_relu 0.

Source files
------------

// File: rtl/relu_requant_if.sv
// Stream bundle for relu_requant: signed accumulator samples in, tagged pixels out.
interface relu_requant_if #(
  parameter int IFMAP_HEIGHT = 128,
  parameter int IFMAP_WIDTH  = 128,
  parameter int ACC_WIDTH    = 20,
  parameter int DATA_WIDTH   = 8
);
  localparam int ROW_W = $clog2(IFMAP_HEIGHT);
  localparam int COL_W = $clog2(IFMAP_WIDTH);

  logic                  in_valid;
  logic                  in_ready;
  logic [ACC_WIDTH-1:0]  in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ROW_W-1:0]      out_row;
  logic [COL_W-1:0]      out_col;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col
  );
endinterface

// File: rtl/relu_requant.sv
// ReLU + right-shift requantization + unsigned saturation, 2-stage pipe with (row,col) tags.
// Optional macro RELU_ROUND_EN selects round-half-up instead of truncation in stage 1.
module relu_requant #(
  parameter int IFMAP_HEIGHT = 128,
  parameter int IFMAP_WIDTH  = 128,
  parameter int ACC_WIDTH    = 20,
  parameter int DATA_WIDTH   = 8,
  parameter int SHIFT        = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  relu_requant_if.slave       bus,
  output logic                sat_flag,
  output logic                done_relu
);
  localparam int ROW_W = $clog2(IFMAP_HEIGHT);
  localparam int COL_W = $clog2(IFMAP_WIDTH);
  localparam int VW    = ACC_WIDTH + 1;
  localparam logic [VW-1:0] SAT_MAX = VW'((1 << DATA_WIDTH) - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t               state, state_next;
  logic                 advance, accept, start, last_in, non_pos;
  logic [ROW_W-1:0]     in_row, s1_row, s2_row;
  logic [COL_W-1:0]     in_col, s1_col, s2_col;
  logic                 s1_valid, s2_valid;
  logic [VW-1:0]        acc_ext, relu_v, s1_v;
  logic [DATA_WIDTH-1:0] s2_data;

  assign advance = !s2_valid || bus.out_ready;
  assign accept  = (state == RUN) && advance && bus.in_valid;
  assign start   = (state == IDLE) && en;
  assign last_in = (in_row == ROW_W'(IFMAP_HEIGHT - 1)) && (in_col == COL_W'(IFMAP_WIDTH - 1));
  assign non_pos = bus.in_data[ACC_WIDTH-1] || (bus.in_data == '0);
  assign acc_ext = {bus.in_data[ACC_WIDTH-1], bus.in_data};

`ifdef RELU_ROUND_EN
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [VW-1:0] RND_BIAS = (SHIFT > 0) ? (VW'(1) << RND_POS) : '0;
  assign relu_v = non_pos ? '0 : ((acc_ext + RND_BIAS) >> SHIFT);
`else
  assign relu_v = non_pos ? '0 : (acc_ext >> SHIFT);
`endif

  assign bus.in_ready  = (state == RUN) && advance;
  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_row   = s2_row;
  assign bus.out_col   = s2_col;
  assign done_relu     = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FLUSH exits as soon as the last pixel is leaving, so DONE lines up with the final transfer
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (accept && last_in) state_next = FLUSH;
      FLUSH:   if (!s1_valid && (!s2_valid || bus.out_ready)) state_next = DONE;
      DONE:    if (!en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_row   <= '0;
      in_col   <= '0;
      s1_valid <= 1'b0;
      s1_v     <= '0;
      s1_row   <= '0;
      s1_col   <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_row   <= '0;
      s2_col   <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (accept) begin
        if (in_col == COL_W'(IFMAP_WIDTH - 1)) begin
          in_col <= '0;
          in_row <= in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
      end
      if (advance) begin
        s1_valid <= accept;
        if (accept) begin
          s1_v   <= relu_v;
          s1_row <= in_row;
          s1_col <= in_col;
        end
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= (s1_v > SAT_MAX) ? '1 : s1_v[DATA_WIDTH-1:0];
          s2_row  <= s1_row;
          s2_col  <= s1_col;
          if (s1_v > SAT_MAX) sat_flag <= 1'b1;
        end
      end
      if (start) begin
        in_row   <= '0;
        in_col   <= '0;
        sat_flag <= 1'b0;
      end
    end
  end
endmodule
